mem_lsu: RTL

Memory-access stage load/store unit between the execute stage and writeback. Consumes the ALU result (address or pass-through value) and rs2 store data, runs a req/ack transaction with data memory for loads and stores, aligns and sign/zero-extends load data, and stalls the upstream pipeline while a transaction is outstanding. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_lsu.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit.
// Runs one req/ack data-memory transaction per aligned load/store, aligns and
// extends load data, stalls upstream while busy, and passes non-memory
// instructions through with one cycle of latency.
module mem_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_alu_data,
    input  logic [31:0] i_rs2_data,
    output logic        o_stall,
    output logic        o_valid,
    output logic [31:0] o_alu_data,
    output logic [31:0] o_ld_data,
    output logic        o_misalign,
    output logic        o_bus_err,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_bmask,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // Count value seen in the last request cycle before a bus error.
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_bmask;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_is_ld;
    logic [31:0] r_alu_hold;
    logic        r_valid;
    logic [31:0] r_alu_out;
    logic [31:0] r_ld_data;
    logic        r_misalign;
    logic        r_bus_err;

    logic        w_memop;
    logic        w_size_h;
    logic        w_size_w;
    logic        w_misalign;
    logic        w_accept;
    logic        w_busy;
    logic        w_timeout;
    logic [3:0]  w_bmask;
    logic [31:0] w_wdata;
    logic [31:0] w_lane;
    logic [31:0] w_ld_ext;

    assign w_memop    = i_valid & (i_mem_rd | i_mem_wr);
    assign w_size_h   = (i_funct3[1:0] == 2'b01);
    assign w_size_w   = i_funct3[1];
    assign w_misalign = (w_size_h & i_alu_data[0]) | (w_size_w & (|i_alu_data[1:0]));
    assign w_accept   = (r_state == S_IDLE) & w_memop & ~w_misalign;
    assign w_busy     = (r_state == S_BUSY);
    // An ack in the final request cycle takes precedence over the timeout.
    assign w_timeout  = w_busy & ~i_dmem_ack & (r_cnt == LP_CNT_LAST);

    // Stall is forced low while reset is asserted so all outputs read zero.
    assign o_stall = i_rst_n & (w_accept | (w_busy & ~i_dmem_ack & ~w_timeout));

    // Store lane replication and byte enables; loads reuse the same mask.
    always_comb begin
        w_bmask = 4'b1111;
        w_wdata = i_rs2_data;
        if (i_funct3[1:0] == 2'b00) begin
            w_bmask = 4'b0001 << i_alu_data[1:0];
            w_wdata = {4{i_rs2_data[7:0]}};
        end else if (w_size_h) begin
            w_bmask = i_alu_data[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_rs2_data[15:0]}};
        end
    end

    // Shift the addressed lane down and sign/zero-extend per captured funct3.
    always_comb begin
        w_lane   = i_dmem_rdata >> {r_off, 3'b000};
        w_ld_ext = w_lane;
        case (r_funct3)
            3'b000:  w_ld_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_ld_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_ld_ext = {24'b0, w_lane[7:0]};
            3'b101:  w_ld_ext = {16'b0, w_lane[15:0]};
            default: w_ld_ext = w_lane;
        endcase
    end

    // IDLE/BUSY controller with registered bus request and retire outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_bmask    <= 4'd0;
            r_funct3   <= 3'd0;
            r_off      <= 2'd0;
            r_is_ld    <= 1'b0;
            r_alu_hold <= 32'd0;
            r_valid    <= 1'b0;
            r_alu_out  <= 32'd0;
            r_ld_data  <= 32'd0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 8'd0;
                    if (w_accept) begin
                        r_state    <= S_BUSY;
                        r_req      <= 1'b1;
                        r_we       <= ~i_mem_rd;
                        r_addr     <= {i_alu_data[31:2], 2'b00};
                        r_wdata    <= w_wdata;
                        r_bmask    <= w_bmask;
                        r_funct3   <= i_funct3;
                        r_off      <= i_alu_data[1:0];
                        r_is_ld    <= i_mem_rd;
                        r_alu_hold <= i_alu_data;
                        r_valid    <= 1'b0;
                        r_ld_data  <= 32'd0;
                        r_misalign <= 1'b0;
                        r_bus_err  <= 1'b0;
                    end else begin
                        r_valid    <= i_valid;
                        r_alu_out  <= i_alu_data;
                        r_ld_data  <= 32'd0;
                        r_misalign <= w_memop & w_misalign;
                        r_bus_err  <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (i_dmem_ack || w_timeout) begin
                        r_state    <= S_IDLE;
                        r_req      <= 1'b0;
                        r_valid    <= 1'b1;
                        r_alu_out  <= r_alu_hold;
                        r_ld_data  <= (i_dmem_ack && r_is_ld) ? w_ld_ext : 32'd0;
                        r_misalign <= 1'b0;
                        r_bus_err  <= ~i_dmem_ack;
                    end else begin
                        r_cnt   <= r_cnt + 8'd1;
                        r_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_valid      = r_valid;
    assign o_alu_data   = r_alu_out;
    assign o_ld_data    = r_ld_data;
    assign o_misalign   = r_misalign;
    assign o_bus_err    = r_bus_err;
    assign o_dmem_req   = r_req;
    assign o_dmem_we    = r_we;
    assign o_dmem_addr  = r_addr;
    assign o_dmem_wdata = r_wdata;
    assign o_dmem_bmask = r_bmask;

endmodule
